// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU definitions used by the register-file write arbiter.
//   REG_ADDR_W / DATA_W : register file geometry (32 x 32)
//   ZERO_REG            : hardwired-zero register, writes to it are no-ops
//   rf_q_entry_t        : one queued mult/div result {live, addr, data}
package rf_write_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_q_entry_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the pipeline / mult-div unit and the write arbiter.
//   wb_*      : pipeline writeback (never stalled)
//   md_*      : mult/div result valid/ready handshake
//   rf_*      : register file write port
//   pending   : per-register mask of queued, live results
// master = pipeline/mult-div/regfile side, slave = arbiter.
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;

  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_write_addr;
  logic [DATA_W-1:0]     wb_write_data;
  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0]     md_data;
  logic                  rf_reg_write;
  logic [REG_ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0]     rf_write_data;
  logic [NUM_REGS-1:0]   pending;

  modport master (
    output wb_reg_write, wb_write_addr, wb_write_data, md_valid, md_addr, md_data,
    input  md_ready, rf_reg_write, rf_write_addr, rf_write_data, pending
  );
  modport slave (
    input  wb_reg_write, wb_write_addr, wb_write_data, md_valid, md_addr, md_data,
    output md_ready, rf_reg_write, rf_write_addr, rf_write_data, pending
  );
endinterface

// File: rtl/rf_wb_queue.sv
// Circular buffer of mult/div results awaiting a free register-file slot.
//   push_i/push_addr_i/push_data_i : enqueue one live entry (caller ensures !full)
//   pop_i                          : drop the head (caller ensures !empty)
//   squash_i/squash_addr_i         : kill every live entry targeting that register
//   head_o, full_o, empty_o        : head entry and occupancy flags
//   pending_o                      : OR of one-hot addr over live entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module rf_wb_queue
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  input  logic [REG_ADDR_W-1:0] squash_addr_i,
  output rf_q_entry_t           head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [NUM_REGS-1:0]   pending_o
);
  localparam int PTR_W = $clog2(DEPTH);

  rf_q_entry_t      ent_q [DEPTH];
  rf_q_entry_t      ent_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  always_comb begin
    ent_d = ent_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // Killed entries keep their slot; they just stop counting as pending
    // and pop silently once they reach the head.
    if (squash_i)
      for (int i = 0; i < DEPTH; i++)
        if (ent_q[i].addr == squash_addr_i) ent_d[i].live = 1'b0;
    if (pop_i) begin
      ent_d[rd_q].live = 1'b0;
      rd_d = rd_q + 1'b1;
    end
    if (push_i) begin
      ent_d[wr_q] = '{live: 1'b1, addr: push_addr_i, data: push_data_i};
      wr_d = wr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_q[i].live) pending_o[ent_q[i].addr] = 1'b1;
    pending_o[ZERO_REG] = 1'b0;
  end

  assign head_o  = ent_q[rd_q];
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of rf_write_arbiter_if (wb_*, md_*, rf_*, pending)
// Pipeline writeback always wins and passes straight through; mult/div
// results are queued and drained into cycles with no effective WB write.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);
  rf_q_entry_t         head;
  logic                q_full, q_empty;
  logic [NUM_REGS-1:0] q_pending;
  logic                wb_eff, md_fire, q_push, q_pop;

  assign wb_eff  = bus.wb_reg_write && (bus.wb_write_addr != ZERO_REG);
  // Ready comes from registered occupancy only: a full queue refuses even
  // in a cycle where it drains, keeping md_ready off the pop path.
  assign bus.md_ready = !reset && !q_full;
  assign md_fire = bus.md_valid && bus.md_ready;
  // r0 results and results already superseded by a same-cycle WB write to
  // the same register complete the handshake but are never enqueued.
  assign q_push  = md_fire && (bus.md_addr != ZERO_REG) &&
                   !(wb_eff && (bus.md_addr == bus.wb_write_addr));
  // Any free slot pops the head, live or killed.
  assign q_pop   = !reset && !wb_eff && !q_empty;

  rf_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk           (clk),
    .reset         (reset),
    .push_i        (q_push),
    .push_addr_i   (bus.md_addr),
    .push_data_i   (bus.md_data),
    .pop_i         (q_pop),
    .squash_i      (wb_eff && !reset),
    .squash_addr_i (bus.wb_write_addr),
    .head_o        (head),
    .full_o        (q_full),
    .empty_o       (q_empty),
    .pending_o     (q_pending)
  );

  always_comb begin
    bus.rf_reg_write  = 1'b0;
    bus.rf_write_addr = '0;
    bus.rf_write_data = '0;
    if (!reset) begin
      if (wb_eff) begin
        bus.rf_reg_write  = 1'b1;
        bus.rf_write_addr = bus.wb_write_addr;
        bus.rf_write_data = bus.wb_write_data;
      end else if (!q_empty && head.live) begin
        bus.rf_reg_write  = 1'b1;
        bus.rf_write_addr = head.addr;
        bus.rf_write_data = head.data;
      end
    end
  end

  assign bus.pending = reset ? '0 : q_pending;
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        rst, wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        mdv;
    logic [4:0]  mda;
    logic [31:0] mdd;
    logic        erw;
    logic [4:0]  era;
    logic [31:0] erd;
    logic        erdy;
    logic [31:0] epend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ww, input logic [4:0] wa,
                              input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                              input logic [31:0] md, input logic ew, input logic [4:0] ea,
                              input logic [31:0] ed, input logic ey, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.wbw = ww; v.wba = wa; v.wbd = wd; v.mdv = mv; v.mda = ma; v.mdd = md;
    v.erw = ew; v.era = ea; v.erd = ed; v.erdy = ey; v.epend = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    rst = r;
    bus.wb_reg_write = ww; bus.wb_write_addr = wa; bus.wb_write_data = wd;
    bus.md_valid = mv; bus.md_addr = ma; bus.md_data = md;
  endtask

  task automatic check_outs(input string tag, input logic ew, input logic [4:0] ea,
                            input logic [31:0] ed, input logic ey, input logic [31:0] ep);
    chk({tag, " rf_we"},   32'(bus.rf_reg_write),  32'(ew));
    chk({tag, " rf_addr"}, 32'(bus.rf_write_addr), 32'(ea));
    chk({tag, " rf_data"}, bus.rf_write_data,      ed);
    chk({tag, " md_rdy"},  32'(bus.md_ready),      32'(ey));
    chk({tag, " pending"}, bus.pending,            ep);
  endtask

  // Reference model: the queue is a plain list of results; a result is
  // "live" until a newer WB write to the same register supersedes it.
  typedef struct { logic [4:0] a; logic [31:0] d; bit live; } me_t;
  me_t mq[$];

  task automatic run_cycle(input string tag, input logic r, input logic ww, input logic [4:0] wa,
                           input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                           input logic [31:0] md);
    logic eff, rdy, ew;
    logic [4:0] ea;
    logic [31:0] ed, ep;
    me_t e;
    drive(r, ww, wa, wd, mv, ma, md);
    eff = ww && (wa != 0);
    rdy = !r && (mq.size() < DEPTH);
    ew = 0; ea = 0; ed = 0; ep = 0;
    if (!r) begin
      foreach (mq[i]) if (mq[i].live) ep[mq[i].a] = 1'b1;
      if (eff) begin ew = 1; ea = wa; ed = wd; end
      else if (mq.size() > 0 && mq[0].live) begin ew = 1; ea = mq[0].a; ed = mq[0].d; end
    end
    @(negedge clk);
    check_outs(tag, ew, ea, ed, rdy, ep);
    @(posedge clk);
    #1;
    if (r) mq.delete();
    else begin
      if (!eff && mq.size() > 0) void'(mq.pop_front());
      if (eff) foreach (mq[i]) if (mq[i].a == wa) mq[i].live = 0;
      if (mv && rdy && ma != 0 && !(eff && ma == wa)) begin
        e.a = ma; e.d = md; e.live = 1; mq.push_back(e);
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    //          rst wbw wba  wbd            mdv mda   mdd           | erw era    erd            rdy pend
    tbl.push_back(mk(1, 0, 0,  0,            0, 0,  0,            0, 0,  0,            0, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    // md push r5, no cut-through, written next cycle
    tbl.push_back(mk(0, 0, 0,  0,            1, 5,  32'h12345678, 0, 0,  0,            1, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            1, 5,  32'h12345678, 1, 32'h20));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    // WB every cycle, md r8/r9/r10: queue fills, r10 refused until first pop
    tbl.push_back(mk(0, 1, 1,  32'h11,       1, 8,  32'h80,       1, 1,  32'h11,       1, 32'h0));
    tbl.push_back(mk(0, 1, 2,  32'h22,       1, 9,  32'h90,       1, 2,  32'h22,       1, 32'h100));
    tbl.push_back(mk(0, 1, 3,  32'h33,       1, 10, 32'hA0,       1, 3,  32'h33,       0, 32'h300));
    tbl.push_back(mk(0, 1, 1,  32'h44,       1, 10, 32'hA0,       1, 1,  32'h44,       0, 32'h300));
    tbl.push_back(mk(0, 0, 0,  0,            1, 10, 32'hA0,       1, 8,  32'h80,       0, 32'h300));
    tbl.push_back(mk(0, 0, 0,  0,            1, 10, 32'hA0,       1, 9,  32'h90,       1, 32'h200));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            1, 10, 32'hA0,       1, 32'h400));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    // squash: queued r7 superseded by WB r7, later pops silently
    tbl.push_back(mk(0, 0, 0,  0,            1, 7,  32'hAAAA,     0, 0,  0,            1, 32'h0));
    tbl.push_back(mk(0, 1, 7,  32'hBBBB,     0, 0,  0,            1, 7,  32'hBBBB,     1, 32'h80));
    tbl.push_back(mk(0, 1, 2,  32'h22,       0, 0,  0,            1, 2,  32'h22,       1, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    // same-cycle md r4 and WB r4
    tbl.push_back(mk(0, 1, 4,  32'h55,       1, 4,  32'h99,       1, 4,  32'h55,       1, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    // md to r0 dropped; WB to r0 is a free slot
    tbl.push_back(mk(0, 0, 0,  0,            1, 0,  32'h123,      0, 0,  0,            1, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 6,  32'h66,       0, 0,  0,            1, 32'h0));
    tbl.push_back(mk(0, 1, 0,  32'hDEAD,     0, 0,  0,            1, 6,  32'h66,       1, 32'h40));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    // fill, then reset with WB and md active
    tbl.push_back(mk(0, 1, 1,  32'h1,        1, 11, 32'hB,        1, 1,  32'h1,        1, 32'h0));
    tbl.push_back(mk(0, 1, 1,  32'h2,        1, 12, 32'hC,        1, 1,  32'h2,        1, 32'h800));
    tbl.push_back(mk(1, 1, 1,  32'h3,        1, 13, 32'hD,        0, 0,  0,            0, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,            1, 32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].wbw, tbl[i].wba, tbl[i].wbd, tbl[i].mdv, tbl[i].mda, tbl[i].mdd);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tbl[i].erw, tbl[i].era, tbl[i].erd, tbl[i].erdy, tbl[i].epend);
      @(posedge clk);
      #1;
    end

    // Model-checked hand sequence: starvation under continuous WB, then drain.
    run_cycle("seq rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      run_cycle($sformatf("starve%0d", i), 0, 1, 5'(1 + i), 32'(i), 1, 5'(20 + i), 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++)
      run_cycle($sformatf("drain%0d", i), 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic on a narrow register range to force collisions.
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      run_cycle($sformatf("rnd%0d", i), r,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter in front of the 32x32 register file. Merges the in-order pipeline writeback stream with results from the long-latency multiply/divide unit, buffering the latter in a small queue until a writeback slot is free. Drives the register file's single write port and exports a pending-write mask so the hazard unit stalls reads of registers with queued results.

## Interface
- DEPTH, 2, queue entries for mult/div results; power of two, ≥2
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- wb_reg_write  in  1  pipeline writeback write enable; always accepted, never stalled
- wb_write_addr  in  5  pipeline writeback destination register
- wb_write_data  in  32  pipeline writeback data
- md_valid  in  1  mult/div result valid
- md_ready  out  1  arbiter can accept a mult/div result
- md_addr  in  5  mult/div destination register
- md_data  in  32  mult/div result
- rf_reg_write  out  1  register file write enable
- rf_write_addr  out  5  register file write address
- rf_write_data  out  32  register file write data
- pending  out  32  bit i = 1 while a queued, live entry targets register i; bit 0 always 0

## Operation
- Effective WB write: wb_reg_write && wb_write_addr != 0. A WB cycle without an effective write is a free slot.
- Output mux, combinational:
  - effective WB write → rf_* = wb_*
  - else free slot and queue head live → rf_* = head entry; head pops this cycle
  - else rf_reg_write = 0; rf_write_addr/rf_write_data = 0
- Push: on md_valid && md_ready. md_addr == 0 → handshake completes, nothing enqueued.
- md_ready = !full. Depends only on registered occupancy, never on a same-cycle pop. A full queue refuses md even in a cycle where it drains.
- Squash: an effective WB write to address A kills every queued live entry with addr A, since the WB value is newer. A same-cycle md push to A is accepted and discarded. Killed entries still occupy slots until popped. When a killed entry reaches the head, it pops in the next free slot without asserting rf_reg_write.
- pending: OR over live entries of their one-hot addr. Registered state, so it changes only after a clock edge.
- Queue order is FIFO; the head pops at most once per cycle.
- Occupancy arithmetic: pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits. Simultaneous push and pop leaves the count unchanged.
- Reset: queue emptied and all entries dead. While reset is high, md_ready = 0, pending = 0 and rf_reg_write = 0 (wb inputs ignored). A result being handshaked during reset is lost; the mult/div unit is reset in the same cycle.

## Timing
- WB path: zero latency, combinational to rf_*.
- md path: push at edge N → earliest rf write in cycle N+1. There is no cut-through, even with an empty queue and a free slot.
- pending bit rises in cycle N+1 after a push at edge N. It falls in the cycle after the pop edge or after the squash edge.
- md_ready falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from full.
- Under continuous effective WB writes the queue does not drain. Starvation is allowed; the hazard unit resolves it via pending.

## Structure
- The shared CPU package holds: REG_ADDR_W = 5, DATA_W = 32, ZERO_REG = 5'd0, and a struct/typedef for {live, addr, data} queue entries.
- One sub-module: rf_wb_queue. It holds the circular buffer with per-entry live bits, push/pop ports, a squash-by-address input, full/empty flags and the pending-mask output.
- rf_write_arbiter holds the output mux, the effective-WB decode and the handshake.

## Test plan
- Idle, then md push r5=0x1234_5678 at edge N with wb_reg_write=0 → cycle N+1: rf_reg_write=1, addr 5, data 0x12345678; pending[5]=1 only during cycle N+1.
- WB writes every cycle to r1..r3 and 3 md pushes (r8, r9, r10) → the first 2 are accepted and md_ready=0 on the third. The queue drains r8 then r9 in the first two WB-free cycles, then r10 is accepted.
- Queue holds r7=0xAAAA; WB writes r7=0xBBBB → pending[7] clears next cycle. The later free-slot pop produces no rf write, and r7 reads back 0xBBBB.
- Same-cycle md push r4 and WB write r4=0x55 → only 0x55 is written; pending[4] never rises.
- md push to r0 → handshake completes, queue stays empty, pending=0, no rf write. WB write to r0 counts as a free slot, and a queued entry drains in that cycle.
- Queue full, assert reset for 1 cycle → md_ready=0, pending=0 and rf_reg_write=0 during reset. After reset the queue is empty, md_ready=1, and no stale writes appear.
